// File: rtl/multi_channel_fifo_queue.sv
// Several independent circular-buffer queues share one write port and drain
// through one registered output stage chosen by a round-robin arbiter.
module multi_channel_fifo_queue #(
  parameter int NUM_CHANNELS               = 4,
  parameter int CHANNEL_ID_WIDTH_IN_BITS   = 2,
  parameter int QUEUE_SIZE                 = 8,
  parameter int QUEUE_PTR_WIDTH_IN_BITS    = 3,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int ALMOST_FULL_THRESHOLD      = 6
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic [CHANNEL_ID_WIDTH_IN_BITS-1:0]   request_channel_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic [CHANNEL_ID_WIDTH_IN_BITS-1:0]   request_channel_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  input  logic                                  flush_in,
  input  logic [CHANNEL_ID_WIDTH_IN_BITS-1:0]   flush_channel_in,
  output logic [NUM_CHANNELS-1:0]               is_empty_out,
  output logic [NUM_CHANNELS-1:0]               is_full_out,
  output logic [NUM_CHANNELS-1:0]               almost_full_out
);

  localparam int CW = CHANNEL_ID_WIDTH_IN_BITS;
  localparam int PW = QUEUE_PTR_WIDTH_IN_BITS;
  localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int AW = CW + PW;

  logic [PW:0]             wr_ptr_vec [NUM_CHANNELS];
  logic [PW:0]             rd_ptr_vec [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wr_hit;
  logic [NUM_CHANNELS-1:0] flush_hit;
  logic [NUM_CHANNELS-1:0] accept;
  logic [NUM_CHANNELS-1:0] eligible;

  logic [DW-1:0] mem [2**AW];

  logic          out_valid_reg;
  logic [DW-1:0] out_data_reg;
  logic [CW-1:0] out_ch_reg;
  logic [CW-1:0] rr_reg;

  logic          pop;
  logic          load;
  logic          take;
  logic          win_found;
  logic [CW-1:0] win_idx;
  logic [CW-1:0] scan_idx;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign pop  = out_valid_reg & issue_ack_in;
  assign load = ~out_valid_reg | pop;
  assign take = load & win_found;

  assign issue_ack_out = reset_n_in & request_valid_in & (|accept);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [PW:0] wr_ptr_reg;
      logic [PW:0] rd_ptr_reg;
      logic [PW:0] occupancy;

      assign wr_hit[gi]    = (request_channel_in == CW'(gi));
      assign flush_hit[gi] = flush_in & (flush_channel_in == CW'(gi));
      assign accept[gi]    = wr_hit[gi] & ~is_full_out[gi] & ~flush_hit[gi];
      // A channel being flushed this edge must not feed the output stage.
      assign eligible[gi]  = ~is_empty_out[gi] & ~flush_hit[gi];

      assign occupancy           = wr_ptr_reg - rd_ptr_reg;
      assign is_empty_out[gi]    = (wr_ptr_reg == rd_ptr_reg);
      assign is_full_out[gi]     = (wr_ptr_reg == {~rd_ptr_reg[PW], rd_ptr_reg[PW-1:0]});
      assign almost_full_out[gi] = (occupancy >= (PW+1)'(ALMOST_FULL_THRESHOLD));

      assign wr_ptr_vec[gi] = wr_ptr_reg;
      assign rd_ptr_vec[gi] = rd_ptr_reg;

      always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else if (flush_hit[gi]) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (issue_ack_out && wr_hit[gi])
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (take && (win_idx == CW'(gi)))
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Scan starts one past the last winner, so every busy channel gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      scan_idx = CW'((int'(rr_reg) + k) % NUM_CHANNELS);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_hit[c])
        wr_addr = {CW'(c), wr_ptr_vec[c][PW-1:0]};
      if (win_idx == CW'(c))
        rd_addr = {CW'(c), rd_ptr_vec[c][PW-1:0]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue_ack_out)
      mem[wr_addr] <= request_in;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_reg        <= CW'(NUM_CHANNELS - 1);
    end else if (load) begin
      if (win_found) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= mem[rd_addr];
        out_ch_reg    <= win_idx;
        rr_reg        <= win_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (flush_in && (flush_channel_in == out_ch_reg)) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign request_valid_out   = out_valid_reg;
  assign request_out         = out_data_reg;
  assign request_channel_out = out_ch_reg;

endmodule

// File: tb/tb_multi_channel_fifo_queue.sv
// Randomised scenarios for multi_channel_fifo_queue, checked every cycle
// against a queue-based model of channels, output stage and round-robin order.
module tb_multi_channel_fifo_queue;

  localparam int N  = 4;
  localparam int QS = 8;
  localparam int AF = 6;
  localparam int OW = 1 + 64 + 2 + 3 * N;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b1;
  logic [63:0] request_in = '0;
  logic [1:0]  request_channel_in = '0;
  logic        request_valid_in = 1'b0;
  logic        issue_ack_out;
  logic [63:0] request_out;
  logic [1:0]  request_channel_out;
  logic        request_valid_out;
  logic        issue_ack_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [1:0]  flush_channel_in = '0;
  logic [N-1:0] is_empty_out;
  logic [N-1:0] is_full_out;
  logic [N-1:0] almost_full_out;

  multi_channel_fifo_queue dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .request_in(request_in), .request_channel_in(request_channel_in),
    .request_valid_in(request_valid_in), .issue_ack_out(issue_ack_out),
    .request_out(request_out), .request_channel_out(request_channel_out),
    .request_valid_out(request_valid_out), .issue_ack_in(issue_ack_in),
    .flush_in(flush_in), .flush_channel_in(flush_channel_in),
    .is_empty_out(is_empty_out), .is_full_out(is_full_out),
    .almost_full_out(almost_full_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq [N][$];
  logic        m_valid;
  logic [63:0] m_data;
  logic [1:0]  m_ch;
  int          m_rr;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) mq[c].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = '0;
    m_rr    = N - 1;
  endfunction

  function automatic logic exp_ack();
    int ch = int'(request_channel_in);
    return reset_n_in && request_valid_in && (ch < N) && (mq[ch].size() < QS) &&
           !(flush_in && flush_channel_in == request_channel_in);
  endfunction

  function automatic logic [OW-1:0] exp_out();
    logic [N-1:0] e, f, a;
    for (int c = 0; c < N; c++) begin
      e[c] = (mq[c].size() == 0);
      f[c] = (mq[c].size() == QS);
      a[c] = (mq[c].size() >= AF);
    end
    return {m_valid, m_valid ? m_data : 64'h0, m_valid ? m_ch : 2'b00, e, f, a};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {request_valid_out, request_valid_out ? request_out : 64'h0,
            request_valid_out ? request_channel_out : 2'b00,
            is_empty_out, is_full_out, almost_full_out};
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  function automatic void model_edge(logic acked);
    logic load = !m_valid || (m_valid && issue_ack_in);
    int   win  = -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_rr + k) % N;
      if (win < 0 && mq[c].size() > 0 && !(flush_in && int'(flush_channel_in) == c))
        win = c;
    end
    if (load) begin
      if (win >= 0) begin
        m_data  = mq[win].pop_front();
        m_ch    = 2'(win);
        m_valid = 1'b1;
        m_rr    = win;
      end else begin
        m_valid = 1'b0;
      end
    end else if (flush_in && flush_channel_in == m_ch) begin
      m_valid = 1'b0;
    end
    if (flush_in) mq[int'(flush_channel_in)].delete();
    if (acked) mq[int'(request_channel_in)].push_back(request_in);
  endfunction

  task automatic apply(input logic v, input logic [1:0] ch, input logic [63:0] d,
                       input logic a, input logic f, input logic [1:0] fc);
    request_valid_in   = v;
    request_channel_in = ch;
    request_in         = d;
    issue_ack_in       = a;
    flush_in           = f;
    flush_channel_in   = fc;
    #1;
  endtask

  task automatic tick();
    logic acked = exp_ack();
    @(posedge clk_in);
    model_edge(acked);
    @(negedge clk_in);
  endtask

  task automatic drain();
    apply(1'b0, 2'd0, 64'h0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 40; i++) tick();
  endtask

  task automatic test_reset();
    request_valid_in = 1'b1;
    #1 reset_n_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    checks++;
    if ({request_valid_out, request_out, request_channel_out, is_empty_out,
         is_full_out, almost_full_out, issue_ack_out} !== {1'b0, 64'h0, 2'b00, 4'hF, 4'h0, 4'h0, 1'b0}) begin
      $display("FAIL reset_state got v=%b d=%h ch=%0d e=%b f=%b af=%b ack=%b want 0/0/0/1111/0000/0000/0",
               request_valid_out, request_out, request_channel_out, is_empty_out,
               is_full_out, almost_full_out, issue_ack_out);
      errors++;
    end
    @(negedge clk_in);
    reset_n_in = 1'b1;
    apply(1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_ch0_order();
    int sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      apply(sent < 4, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF - 64'(sent), 1'b1, 1'b0, 2'd0);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL ch0_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      if (exp_ack()) sent++;
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL ch0_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_fill_ch2();
    int sent = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      apply(sent < 10, 2'd2, 64'h2000 + 64'(sent), cyc == 12, 1'b0, 2'd0);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL fill_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      if (exp_ack()) sent++;
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL fill_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [1:0] chs [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    int sent = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      apply(sent < 6, chs[sent % 6], 64'h3000 + 64'(sent), cyc >= 6, 1'b0, 2'd0);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL rr_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      if (exp_ack()) sent++;
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL rr_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_hold();
    for (int cyc = 0; cyc < 14; cyc++) begin
      apply(cyc < 3, 2'(cyc), 64'h4000 + 64'(cyc), cyc >= 8, 1'b0, 2'd0);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL hold_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL hold_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_flush();
    logic [1:0] chs [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3};
    for (int cyc = 0; cyc < 16; cyc++) begin
      apply(cyc < 6, cyc < 6 ? chs[cyc] : 2'd0, 64'h5000 + 64'(cyc),
            cyc >= 8, cyc == 7, 2'd1);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL flush_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL flush_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      apply(1'b1, 2'd3, 64'h6000 + 64'(cyc), 1'b0, 1'b0, 2'd0);
      tick();
    end
    #2 reset_n_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({request_valid_out, is_empty_out, is_full_out} !== {1'b0, 4'hF, 4'h0}) begin
      $display("FAIL async_reset got v=%b e=%b f=%b want 0/1111/0000",
               request_valid_out, is_empty_out, is_full_out);
      errors++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      apply(cyc == 0, 2'd2, 64'hA5A5_0000_0000_5A5A, 1'b0, 1'b0, 2'd0);
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL post_reset_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL post_reset_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      apply($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
      checks++;
      if (issue_ack_out !== exp_ack()) begin
        $display("FAIL rand_ack cyc=%0d got %b want %b", cyc, issue_ack_out, exp_ack()); errors++;
      end
      tick();
      checks++;
      if (dut_out() !== exp_out()) begin
        $display("FAIL rand_out cyc=%0d got %h want %h", cyc, dut_out(), exp_out()); errors++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ch0_order();
    test_fill_ch2();
    test_round_robin();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
